line_buffer: RTL and testbench
==============================

# line_buffer

Single-entry write-back line buffer between the CPU's 32-bit memory port and the cacheline adaptor's 256-bit line port. It holds one 32-byte line with its tag, valid bit and dirty bit. Hits are served from the buffer. Misses write back a dirty victim if needed, then fill the line through the adaptor. The upstream side is word-granular with byte enables; the downstream side issues whole-line read and write requests.

## Interface
Parameters: none; all widths are fixed by the package.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- mem_address  in  32  CPU byte address; bits [1:0] are ignored
- mem_read  in  1  read request; held until mem_resp
- mem_write  in  1  write request; held until mem_resp
- mem_byte_enable  in  4  write byte lanes
- mem_wdata  in  32  write data
- mem_rdata  out  32  read data; valid while mem_resp is high
- mem_resp  out  1  one-cycle completion pulse
- pmem_address  out  32  line address; bits [4:0] are always 0
- pmem_read  out  1  line fill request
- pmem_write  out  1  line write-back request
- pmem_wdata  out  256  victim line; always driven from the line register
- pmem_rdata  in  256  fill data
- pmem_resp  in  1  line transfer complete (one-cycle pulse)

## Operation
- Address split:
  - tag = addr[31:5]
  - word index = addr[4:2]
  - word w occupies line bits [32w+31:32w]
- Hit: valid && stored tag == mem_address[31:5].
- State machine: IDLE, WB, GAP, FILL, RESP.
- IDLE: a request is sampled only in this state.
  - Both mem_read and mem_write high is illegal; mem_write takes priority.
  - Hit read: mem_rdata <= selected word; go to RESP.
  - Hit write: merge mem_wdata into the selected word under mem_byte_enable; dirty <= 1; go to RESP.
  - Miss with valid && dirty: go to WB. pmem_address <= {stored tag, 5'b0}; pmem_write <= 1.
  - Miss otherwise: go to FILL. pmem_address <= {mem_address[31:5], 5'b0}; pmem_read <= 1.
- WB: hold all outputs until pmem_resp. Then pmem_write <= 0, dirty <= 0, go to GAP.
- GAP: exactly one cycle with pmem_read = pmem_write = 0. Then pmem_address <= fill address; pmem_read <= 1; go to FILL.
- FILL: wait for pmem_resp. On that edge:
  - line <= pmem_rdata, with the pending write merged if the request is a write
  - tag <= request tag; valid <= 1
  - dirty <= 1 for a write, 0 for a read
  - mem_rdata <= selected word of pmem_rdata
  - pmem_read <= 0; go to RESP
- RESP: mem_resp = 1 for exactly one cycle, then go to IDLE. The CPU must change or drop its request on the following cycle.
- mem_rdata holds its last value outside RESP.
- pmem_read and pmem_write are never high together.
- Reset, including mid-transfer: force IDLE immediately.
  - valid = 0, dirty = 0, tag = 0, line = 0
  - mem_resp = 0, mem_rdata = 0
  - pmem_read = 0, pmem_write = 0, pmem_address = 0; pmem_wdata = 0
  - An adaptor transfer in flight is abandoned; the adaptor is reset together with this block.

## Timing
- Hit: request sampled at edge N; mem_resp high during cycle N+1.
- Clean miss:
  - pmem_read high from cycle N+1.
  - pmem_resp sampled at edge M.
  - mem_resp high during cycle M+1; pmem_read low from M+1.
- Dirty miss:
  - pmem_write high from N+1 until pmem_resp at edge W.
  - GAP occupies cycle W+1.
  - pmem_read high from W+2; then as for a clean miss.
- Request sampling resumes at edge N+2 of a hit, or M+2 of a miss. This guarantees at least one idle cycle between adaptor requests, which the adaptor needs for its signal-release cycle.

## Configuration
- LINE_BUFFER_PERF_EN defined adds two ports:
  - hit_count  out  32
  - miss_count  out  32
- Counter behaviour:
  - Each counter increments once per request sampled in IDLE, by hit or miss.
  - Both saturate at 32'hFFFF_FFFF.
  - Both reset to 0.
- LINE_BUFFER_PERF_EN undefined: the ports and counters are absent; the rest of the behaviour is identical.

## Structure
- Package line_buffer_pkg holds:
  - state enum line_buffer_state_e
  - OFFSET_BITS = 5
  - TAG_BITS = 27
  - WORDS_PER_LINE = 8
  - LINE_BITS = 256
- Sub-module line_buffer_merge: combinational; takes line, word index, byte enable and wdata, and returns the merged 256-bit line. It is used in IDLE-hit writes and in FILL.

## Test plan
- Read 0x0000_1004 after reset, with fill data word1 = 0xDEAD_BEEF -> pmem_read at 0x0000_1000; mem_resp with mem_rdata = 0xDEAD_BEEF; no pmem_write.
- Read 0x0000_1008 after that fill -> mem_resp one cycle after sampling, with no pmem activity.
- Write 0x0000_100C, byte_enable 4'b0011, data 0x1234_5678, over old word 0xAABB_CCDD -> next read of the same address returns 0xAABB_5678; dirty is set.
- Read 0x0000_2000 while the line is dirty -> pmem_write at 0x0000_1000 with pmem_wdata equal to the modified line; one GAP cycle; pmem_read at 0x0000_2000; mem_resp after the fill.
- Write miss to 0x0000_3010, byte_enable 4'b1111, data 0xCAFE_F00D -> fill from 0x0000_3000 with the write merged into word 4; dirty = 1; mem_resp.
- Assert reset during WB -> pmem_write drops without waiting for a clock edge; next read of 0x0000_1000 misses (valid = 0). With LINE_BUFFER_PERF_EN defined, counters read 0 after reset.

Source files
------------

// File: rtl/line_buffer_pkg.sv
// Shared widths, FSM state type and word-select helper for the line buffer.
package line_buffer_pkg;

  localparam int unsigned OFFSET_BITS    = 5;
  localparam int unsigned TAG_BITS       = 27;
  localparam int unsigned WORDS_PER_LINE = 8;
  localparam int unsigned LINE_BITS      = 256;
  localparam int unsigned WORD_BITS      = 32;
  localparam int unsigned INDEX_BITS     = $clog2(WORDS_PER_LINE);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WB   = 3'd1,
    GAP  = 3'd2,
    FILL = 3'd3,
    RESP = 3'd4
  } line_buffer_state_e;

  // Extract 32-bit word idx from a line (word w at bits [32w+31:32w]).
  function automatic logic [WORD_BITS-1:0] word_sel(input logic [LINE_BITS-1:0]  line,
                                                    input logic [INDEX_BITS-1:0] idx);
    return line[{idx, 5'b0} +: WORD_BITS];
  endfunction

endpackage

// File: rtl/line_buffer_merge.sv
// Byte-lane merge of a 32-bit write into one word of a 256-bit line.
import line_buffer_pkg::*;

module line_buffer_merge (
  input  logic [LINE_BITS-1:0]  line_i,
  input  logic [INDEX_BITS-1:0] word_idx_i,
  input  logic [3:0]            byte_en_i,
  input  logic [WORD_BITS-1:0]  wdata_i,
  output logic [LINE_BITS-1:0]  line_o
);

  // Overwrite only the enabled byte lanes of the selected word.
  always_comb begin
    line_o = line_i;
    for (int b = 0; b < 4; b++) begin
      if (byte_en_i[b]) begin
        line_o[{word_idx_i, 2'(b), 3'b0} +: 8] = wdata_i[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/line_buffer.sv
// Single-entry write-back line buffer between a 32-bit CPU port and a
// 256-bit cacheline adaptor. Optional LINE_BUFFER_PERF_EN adds saturating
// hit/miss counters.
import line_buffer_pkg::*;

module line_buffer (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          mem_address,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [3:0]           mem_byte_enable,
  input  logic [31:0]          mem_wdata,
  output logic [31:0]          mem_rdata,
  output logic                 mem_resp,
  output logic [31:0]          pmem_address,
  output logic                 pmem_read,
  output logic                 pmem_write,
  output logic [LINE_BITS-1:0] pmem_wdata,
  input  logic [LINE_BITS-1:0] pmem_rdata,
  input  logic                 pmem_resp
`ifdef LINE_BUFFER_PERF_EN
  ,
  output logic [31:0]          hit_count,
  output logic [31:0]          miss_count
`endif
);

  line_buffer_state_e   state_q, state_d;
  logic                 valid_q, valid_d;
  logic                 dirty_q, dirty_d;
  logic [TAG_BITS-1:0]  tag_q, tag_d;
  logic [LINE_BITS-1:0] line_q, line_d;
  logic [31:0]          mem_rdata_q, mem_rdata_d;
  logic                 mem_resp_q, mem_resp_d;
  logic [31:0]          pmem_address_q, pmem_address_d;
  logic                 pmem_read_q, pmem_read_d;
  logic                 pmem_write_q, pmem_write_d;
`ifdef LINE_BUFFER_PERF_EN
  logic [31:0]          hit_cnt_q, hit_cnt_d;
  logic [31:0]          miss_cnt_q, miss_cnt_d;
`endif

  logic [TAG_BITS-1:0]   req_tag;
  logic [INDEX_BITS-1:0] req_idx;
  logic                  hit;
  logic [LINE_BITS-1:0]  merge_base;
  logic [LINE_BITS-1:0]  merged_line;
  logic                  unused_addr;

  assign req_tag     = mem_address[31:OFFSET_BITS];
  assign req_idx     = mem_address[OFFSET_BITS-1:2];
  assign hit         = valid_q && (tag_q == req_tag);
  assign unused_addr = ^mem_address[1:0];

  // The merge operates on the stored line for hits and on the incoming fill in FILL.
  assign merge_base = (state_q == FILL) ? pmem_rdata : line_q;

  line_buffer_merge u_merge (
    .line_i     (merge_base),
    .word_idx_i (req_idx),
    .byte_en_i  (mem_byte_enable),
    .wdata_i    (mem_wdata),
    .line_o     (merged_line)
  );

  // State register and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      valid_q        <= 1'b0;
      dirty_q        <= 1'b0;
      tag_q          <= '0;
      line_q         <= '0;
      mem_rdata_q    <= '0;
      mem_resp_q     <= 1'b0;
      pmem_address_q <= '0;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
`ifdef LINE_BUFFER_PERF_EN
      hit_cnt_q      <= '0;
      miss_cnt_q     <= '0;
`endif
    end else begin
      state_q        <= state_d;
      valid_q        <= valid_d;
      dirty_q        <= dirty_d;
      tag_q          <= tag_d;
      line_q         <= line_d;
      mem_rdata_q    <= mem_rdata_d;
      mem_resp_q     <= mem_resp_d;
      pmem_address_q <= pmem_address_d;
      pmem_read_q    <= pmem_read_d;
      pmem_write_q   <= pmem_write_d;
`ifdef LINE_BUFFER_PERF_EN
      hit_cnt_q      <= hit_cnt_d;
      miss_cnt_q     <= miss_cnt_d;
`endif
    end
  end

  // Next-state and next-output logic; requests are only sampled in IDLE.
  always_comb begin
    state_d        = state_q;
    valid_d        = valid_q;
    dirty_d        = dirty_q;
    tag_d          = tag_q;
    line_d         = line_q;
    mem_rdata_d    = mem_rdata_q;
    mem_resp_d     = 1'b0;
    pmem_address_d = pmem_address_q;
    pmem_read_d    = pmem_read_q;
    pmem_write_d   = pmem_write_q;
`ifdef LINE_BUFFER_PERF_EN
    hit_cnt_d      = hit_cnt_q;
    miss_cnt_d     = miss_cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (mem_read || mem_write) begin
          if (hit) begin
            if (mem_write) begin
              line_d  = merged_line;
              dirty_d = 1'b1;
            end else begin
              mem_rdata_d = word_sel(line_q, req_idx);
            end
            mem_resp_d = 1'b1;
            state_d    = RESP;
`ifdef LINE_BUFFER_PERF_EN
            if (hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_d = hit_cnt_q + 32'd1;
`endif
          end else begin
            if (valid_q && dirty_q) begin
              pmem_address_d = {tag_q, OFFSET_BITS'(0)};
              pmem_write_d   = 1'b1;
              state_d        = WB;
            end else begin
              pmem_address_d = {req_tag, OFFSET_BITS'(0)};
              pmem_read_d    = 1'b1;
              state_d        = FILL;
            end
`ifdef LINE_BUFFER_PERF_EN
            if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_d = miss_cnt_q + 32'd1;
`endif
          end
        end
      end
      WB: begin
        if (pmem_resp) begin
          pmem_write_d = 1'b0;
          dirty_d      = 1'b0;
          state_d      = GAP;
        end
      end
      GAP: begin
        pmem_address_d = {req_tag, OFFSET_BITS'(0)};
        pmem_read_d    = 1'b1;
        state_d        = FILL;
      end
      FILL: begin
        if (pmem_resp) begin
          line_d      = mem_write ? merged_line : pmem_rdata;
          tag_d       = req_tag;
          valid_d     = 1'b1;
          dirty_d     = mem_write;
          mem_rdata_d = word_sel(pmem_rdata, req_idx);
          mem_resp_d  = 1'b1;
          pmem_read_d = 1'b0;
          state_d     = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign mem_rdata    = mem_rdata_q;
  assign mem_resp     = mem_resp_q;
  assign pmem_address = pmem_address_q;
  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign pmem_wdata   = line_q;
`ifdef LINE_BUFFER_PERF_EN
  assign hit_count    = hit_cnt_q;
  assign miss_count   = miss_cnt_q;
`endif

endmodule

// File: tb/tb_line_buffer.sv
// Directed, table-driven bench for line_buffer with a small adaptor responder.
module tb_line_buffer;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [3:0]   mem_byte_enable;
  logic [31:0]  mem_wdata;
  logic [31:0]  mem_rdata;
  logic         mem_resp;
  logic [31:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
`ifdef LINE_BUFFER_PERF_EN
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  line_buffer dut (
    .clk             (clk),
    .reset           (reset),
    .mem_address     (mem_address),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp),
    .pmem_address    (pmem_address),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_wdata      (pmem_wdata),
    .pmem_rdata      (pmem_rdata),
    .pmem_resp       (pmem_resp)
`ifdef LINE_BUFFER_PERF_EN
    ,
    .hit_count       (hit_count),
    .miss_count      (miss_count)
`endif
  );

  typedef struct {
    logic         wr;
    logic         rd;
    logic [31:0]  addr;
    logic [3:0]   be;
    logic [31:0]  wdata;
    logic         miss;
    logic         wb;
    logic [31:0]  wb_addr;
    logic [255:0] wb_data;
    logic [255:0] fill;
    logic         chk;
    logic [31:0]  rdata;
  } vec_t;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] mk_line(input logic [31:0] base);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = base + 32'(i);
    return l;
  endfunction

  function automatic logic [255:0] set_w(input logic [255:0] l, input int idx, input logic [31:0] val);
    logic [255:0] r;
    r = l;
    r[32*idx +: 32] = val;
    return r;
  endfunction

  function automatic vec_t mkv(input logic wr, input logic rd, input logic [31:0] addr,
                               input logic [3:0] be, input logic [31:0] wdata,
                               input logic miss, input logic wb, input logic [31:0] wb_addr,
                               input logic [255:0] wb_data, input logic [255:0] fill,
                               input logic chkr, input logic [31:0] rdata);
    vec_t v;
    v.wr = wr; v.rd = rd; v.addr = addr; v.be = be; v.wdata = wdata;
    v.miss = miss; v.wb = wb; v.wb_addr = wb_addr; v.wb_data = wb_data;
    v.fill = fill; v.chk = chkr; v.rdata = rdata;
    return v;
  endfunction

  // Drive one request, act as the adaptor (2-cycle latency) and check timing/data.
  task automatic run_req(input vec_t v, input int k);
    int  cyc;
    int  wb_cyc;
    int  rd_cyc;
    int  wb_resp_cyc;
    int  rd_resp_cyc;
    bit  done;
    bit  saw_wb;
    bit  saw_rd;
    cyc = 0; wb_cyc = 0; rd_cyc = 0; wb_resp_cyc = 0; rd_resp_cyc = 0;
    done = 0; saw_wb = 0; saw_rd = 0;
    mem_address     = v.addr;
    mem_read        = v.rd;
    mem_write       = v.wr;
    mem_byte_enable = v.be;
    mem_wdata       = v.wdata;
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      pmem_resp = 1'b0;
      if (pmem_read && pmem_write) chk($sformatf("v%0d rd_wr_exclusive", k), 1'b1, 1'b0);
      if (pmem_write) begin
        if (!saw_wb) begin
          saw_wb = 1;
          chk($sformatf("v%0d wb_start_cycle", k), 256'(cyc), 256'd1);
          chk($sformatf("v%0d wb_addr", k), pmem_address, v.wb_addr);
          chk($sformatf("v%0d wb_data", k), pmem_wdata, v.wb_data);
        end
        wb_cyc++;
        if (wb_cyc == 2) begin
          pmem_resp   = 1'b1;
          wb_resp_cyc = cyc;
        end
      end
      if (pmem_read) begin
        if (!saw_rd) begin
          saw_rd = 1;
          chk($sformatf("v%0d fill_start_cycle", k), 256'(cyc),
              256'(v.wb ? wb_resp_cyc + 2 : 1));
          chk($sformatf("v%0d fill_addr", k), pmem_address, {v.addr[31:5], 5'b0});
        end
        rd_cyc++;
        if (rd_cyc == 2) begin
          pmem_rdata  = v.fill;
          pmem_resp   = 1'b1;
          rd_resp_cyc = cyc;
        end
      end
      if (mem_resp) begin
        done = 1;
        chk($sformatf("v%0d resp_cycle", k), 256'(cyc), 256'(v.miss ? rd_resp_cyc + 1 : 1));
        chk($sformatf("v%0d saw_fill", k), saw_rd, v.miss);
        chk($sformatf("v%0d saw_wb", k), saw_wb, v.wb);
        chk($sformatf("v%0d pmem_idle_at_resp", k), {pmem_read, pmem_write}, 2'b00);
        if (v.chk) chk($sformatf("v%0d rdata", k), mem_rdata, v.rdata);
      end
    end
    if (!done) chk($sformatf("v%0d resp_timeout", k), 1'b0, 1'b1);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    @(negedge clk);
    pmem_resp = 1'b0;
    chk($sformatf("v%0d resp_one_cycle", k), mem_resp, 1'b0);
    if (v.chk) chk($sformatf("v%0d rdata_hold", k), mem_rdata, v.rdata);
  endtask

  vec_t         vecs[14];
  vec_t         vpost;
  logic [255:0] fill_a, fill_b, fill_c, fill_d, fill_e, wb_a, wb_c;

  initial begin
    reset = 1'b1;
    mem_address = '0; mem_read = 1'b0; mem_write = 1'b0;
    mem_byte_enable = '0; mem_wdata = '0;
    pmem_rdata = '0; pmem_resp = 1'b0;

    fill_a = set_w(set_w(mk_line(32'h1000_0000), 1, 32'hDEAD_BEEF), 3, 32'hAABB_CCDD);
    wb_a   = set_w(fill_a, 3, 32'hAABB_5678);
    fill_b = mk_line(32'h2000_0000);
    fill_c = mk_line(32'h3000_0000);
    wb_c   = set_w(set_w(fill_c, 4, 32'hCAFE_F00D), 1, 32'h7700_0001);
    fill_d = mk_line(32'h4000_0000);
    fill_e = mk_line(32'h5000_0000);

    //              wr rd addr           be       wdata          miss wb wb_addr       wb_data fill    chk rdata
    vecs[0]  = mkv(0, 1, 32'h0000_1004, 4'h0, 32'h0,          1, 0, 32'h0,        '0,     fill_a, 1, 32'hDEAD_BEEF);
    vecs[1]  = mkv(0, 1, 32'h0000_1008, 4'h0, 32'h0,          0, 0, 32'h0,        '0,     '0,     1, 32'h1000_0002);
    vecs[2]  = mkv(1, 0, 32'h0000_100C, 4'h3, 32'h1234_5678,  0, 0, 32'h0,        '0,     '0,     0, 32'h0);
    vecs[3]  = mkv(0, 1, 32'h0000_100C, 4'h0, 32'h0,          0, 0, 32'h0,        '0,     '0,     1, 32'hAABB_5678);
    vecs[4]  = mkv(0, 1, 32'h0000_2000, 4'h0, 32'h0,          1, 1, 32'h0000_1000, wb_a,  fill_b, 1, 32'h2000_0000);
    vecs[5]  = mkv(0, 1, 32'h0000_201C, 4'h0, 32'h0,          0, 0, 32'h0,        '0,     '0,     1, 32'h2000_0007);
    vecs[6]  = mkv(1, 0, 32'h0000_3010, 4'hF, 32'hCAFE_F00D,  1, 0, 32'h0,        '0,     fill_c, 1, 32'h3000_0004);
    vecs[7]  = mkv(0, 1, 32'h0000_3010, 4'h0, 32'h0,          0, 0, 32'h0,        '0,     '0,     1, 32'hCAFE_F00D);
    vecs[8]  = mkv(0, 1, 32'h0000_3004, 4'h0, 32'h0,          0, 0, 32'h0,        '0,     '0,     1, 32'h3000_0001);
    vecs[9]  = mkv(1, 0, 32'h0000_3006, 4'h8, 32'h7700_0000,  0, 0, 32'h0,        '0,     '0,     0, 32'h0);
    vecs[10] = mkv(0, 1, 32'h0000_3004, 4'h0, 32'h0,          0, 0, 32'h0,        '0,     '0,     1, 32'h7700_0001);
    vecs[11] = mkv(0, 1, 32'h0000_4008, 4'h0, 32'h0,          1, 1, 32'h0000_3000, wb_c,  fill_d, 1, 32'h4000_0002);
    vecs[12] = mkv(1, 1, 32'h0000_4008, 4'h4, 32'h00AB_0000,  0, 0, 32'h0,        '0,     '0,     0, 32'h0);
    vecs[13] = mkv(0, 1, 32'h0000_400B, 4'h0, 32'h0,          0, 0, 32'h0,        '0,     '0,     1, 32'h40AB_0002);
    vpost    = mkv(0, 1, 32'h0000_1000, 4'h0, 32'h0,          1, 0, 32'h0,        '0,     fill_e, 1, 32'h5000_0000);

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst mem_resp", mem_resp, 1'b0);
    chk("rst mem_rdata", mem_rdata, 32'h0);
    chk("rst pmem_ctl", {pmem_read, pmem_write}, 2'b00);
    chk("rst pmem_address", pmem_address, 32'h0);
    chk("rst pmem_wdata", pmem_wdata, 256'h0);
`ifdef LINE_BUFFER_PERF_EN
    chk("rst hit_count", hit_count, 32'h0);
    chk("rst miss_count", miss_count, 32'h0);
`endif
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 14; i++) run_req(vecs[i], i);

`ifdef LINE_BUFFER_PERF_EN
    chk("perf hit_count", hit_count, 32'd10);
    chk("perf miss_count", miss_count, 32'd4);
`endif

    // Reset in the middle of a write-back of the dirty 0x4000 line
    mem_address = 32'h0000_1000;
    mem_read    = 1'b1;
    @(negedge clk);
    chk("rstwb pmem_write_up", pmem_write, 1'b1);
    chk("rstwb wb_addr", pmem_address, 32'h0000_4000);
    #2 reset = 1'b1;
    #1;
    chk("rstwb pmem_write_async", pmem_write, 1'b0);
    chk("rstwb pmem_read_async", pmem_read, 1'b0);
    chk("rstwb pmem_address", pmem_address, 32'h0);
    chk("rstwb pmem_wdata", pmem_wdata, 256'h0);
    chk("rstwb mem_rdata", mem_rdata, 32'h0);
    mem_read = 1'b0;
    @(negedge clk);
    reset = 1'b0;
`ifdef LINE_BUFFER_PERF_EN
    chk("rstwb hit_count", hit_count, 32'h0);
    chk("rstwb miss_count", miss_count, 32'h0);
`endif
    @(negedge clk);
    run_req(vpost, 14);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
